// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } find_res_t;

    // One-hot vector with bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // First set bit of vec scanning start, start+1, ... with mod-N_REQ wrap.
    function automatic find_res_t rr_find_first(input logic [N_REQ-1:0] vec,
                                                input logic [IDX_W-1:0] start);
        find_res_t        res;
        logic [IDX_W-1:0] pos;
        res = '0;
        // Scan from farthest to nearest so the nearest hit is written last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            pos = start + IDX_W'(k);
            if (vec[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic                 en;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_vld;

    modport master (output en, output req, input gnt, input gnt_idx, input gnt_vld);
    modport slave  (input en, input req, output gnt, output gnt_idx, output gnt_vld);
endinterface

// File: rtl/onehot_enc8.sv
// Combinational 8-to-3 one-hot encoder; all-zero input encodes to 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot_in,
    output logic [IDX_W-1:0] idx
);

    // OR together the indices of set bits; exact for one-hot or zero input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (onehot_in[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold and registered one-hot grant.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    arb_state_e       state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [IDX_W-1:0] owner_q, owner_n;
    logic [HOLD_W-1:0] cnt_q, cnt_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic             vld_q;

    logic [N_REQ-1:0] others;
    logic [IDX_W-1:0] ptr_inc;
    find_res_t        win_idle;
    find_res_t        win_rot;

    // Next-state: arbitration, hold counting and rotation.
    always_comb begin
        others   = bus.req & ~onehot(owner_q);
        ptr_inc  = owner_q + IDX_W'(1);
        win_idle = rr_find_first(bus.req, ptr_q);
        win_rot  = rr_find_first(others, ptr_inc);

        state_n  = state_q;
        ptr_n    = ptr_q;
        owner_n  = owner_q;
        cnt_n    = cnt_q;
        gnt_n    = gnt_q;

        if (!bus.en) begin
            state_n = IDLE;
            cnt_n   = '0;
            gnt_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    gnt_n = '0;
                    cnt_n = '0;
                    if (win_idle.found) begin
                        state_n = GRANT;
                        owner_n = win_idle.idx;
                        gnt_n   = onehot(win_idle.idx);
                        cnt_n   = HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (!bus.req[owner_q]) begin
                        // Owner released: hand off with no idle bubble if possible.
                        ptr_n = ptr_inc;
                        if (win_rot.found) begin
                            owner_n = win_rot.idx;
                            gnt_n   = onehot(win_rot.idx);
                            cnt_n   = HOLD_W'(1);
                        end else begin
                            state_n = IDLE;
                            gnt_n   = '0;
                            cnt_n   = '0;
                        end
                    end else if (cnt_q < HOLD_W'(MAX_HOLD)) begin
                        cnt_n = cnt_q + HOLD_W'(1);
                    end else if (win_rot.found) begin
                        // Hold limit reached with competition: force rotation.
                        ptr_n   = ptr_inc;
                        owner_n = win_rot.idx;
                        gnt_n   = onehot(win_rot.idx);
                        cnt_n   = HOLD_W'(1);
                    end else begin
                        cnt_n = HOLD_W'(MAX_HOLD);
                    end
                end
                default: begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
            gnt_q   <= gnt_n;
            vld_q   <= |gnt_n;
        end
    end

    onehot_enc8 u_enc (
        .onehot_in (gnt_q),
        .idx       (bus.gnt_idx)
    );

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = vld_q;

endmodule
